pipe_stage_reg: RTL and testbench

PIPE_STAGE_REG -- requirements
Module: pipe_stage_reg

---
 rtl/pipe_stage_reg.sv | 107 ++++++++++
 tb/tb_pipe_stage_reg.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/pipe_stage_reg.sv
// Pipeline stage register with stall/flush/bubble control and saturating
// performance counters for hold, bubble and squash events.
module pipe_stage_reg #(
    parameter int                DATA_W          = 32,
    parameter int                STALL_W         = 6,
    parameter int                STAGE           = 4,
    parameter logic [DATA_W-1:0] NOP_VALUE       = '0,
    parameter bit                CLEAR_ON_BUBBLE = 1'b1,
    parameter int                CNT_W           = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [STALL_W-1:0] stall,
    input  logic              flush,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    input  logic              cnt_clr,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_data,
    output logic [CNT_W-1:0]  hold_cnt,
    output logic [CNT_W-1:0]  bubble_cnt,
    output logic [CNT_W-1:0]  squash_cnt
);

    generate
        if (STAGE < 0 || STAGE > STALL_W - 2) begin : g_bad_stage
            $fatal(1, "pipe_stage_reg: STAGE must lie in 0..STALL_W-2");
        end
        if (DATA_W < 1 || DATA_W > 256) begin : g_bad_width
            $fatal(1, "pipe_stage_reg: DATA_W must lie in 1..256");
        end
    endgenerate

    typedef enum logic [1:0] {
        ACT_FLUSH,
        ACT_BUBBLE,
        ACT_LOAD,
        ACT_HOLD
    } act_t;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic up;
    logic dn;
    act_t act;

    assign up = stall[STAGE];
    assign dn = stall[STAGE+1];

    always_comb begin
        act = ACT_HOLD;
        if (flush)
            act = ACT_FLUSH;
        else if (up && !dn)
            act = ACT_BUBBLE;
        else if (!up)
            act = ACT_LOAD;
        else
            act = ACT_HOLD;
    end

    // Payload and valid register
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_data  <= NOP_VALUE;
        end else begin
            case (act)
                ACT_FLUSH, ACT_BUBBLE: begin
                    out_valid <= 1'b0;
                    if (CLEAR_ON_BUBBLE)
                        out_data <= NOP_VALUE;
                end
                ACT_LOAD: begin
                    out_valid <= in_valid;
                    out_data  <= in_data;
                end
                default: ;
            endcase
        end
    end

    logic hold_inc;
    logic bubble_inc;
    logic squash_inc;

    assign hold_inc   = (act == ACT_HOLD);
    assign bubble_inc = (act == ACT_BUBBLE);
    assign squash_inc = (act == ACT_FLUSH) && out_valid;

    // Saturating counters; clear wins over a same-edge increment
    always_ff @(posedge clk) begin
        if (rst || cnt_clr) begin
            hold_cnt   <= '0;
            bubble_cnt <= '0;
            squash_cnt <= '0;
        end else begin
            if (hold_inc && hold_cnt != CNT_MAX)
                hold_cnt <= hold_cnt + 1'b1;
            if (bubble_inc && bubble_cnt != CNT_MAX)
                bubble_cnt <= bubble_cnt + 1'b1;
            if (squash_inc && squash_cnt != CNT_MAX)
                squash_cnt <= squash_cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Directed bench for pipe_stage_reg: one instance clearing on bubble, one
// holding the payload on bubble, both with 4-bit counters.
module tb_pipe_stage_reg;

    logic        clk = 1'b0;
    logic        rst;
    logic [5:0]  stall;
    logic        flush;
    logic        in_valid;
    logic [31:0] in_data;
    logic        cnt_clr;

    logic        out_valid,  out_valid2;
    logic [31:0] out_data,   out_data2;
    logic [3:0]  hold_cnt,   hold_cnt2;
    logic [3:0]  bubble_cnt, bubble_cnt2;
    logic [3:0]  squash_cnt, squash_cnt2;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    pipe_stage_reg #(.DATA_W(32), .STALL_W(6), .STAGE(4), .NOP_VALUE(32'h0),
                     .CLEAR_ON_BUBBLE(1'b1), .CNT_W(4)) dut (
        .clk(clk), .rst(rst), .stall(stall), .flush(flush),
        .in_valid(in_valid), .in_data(in_data), .cnt_clr(cnt_clr),
        .out_valid(out_valid), .out_data(out_data), .hold_cnt(hold_cnt),
        .bubble_cnt(bubble_cnt), .squash_cnt(squash_cnt)
    );

    pipe_stage_reg #(.DATA_W(32), .STALL_W(6), .STAGE(4), .NOP_VALUE(32'h0),
                     .CLEAR_ON_BUBBLE(1'b0), .CNT_W(4)) dut_hold (
        .clk(clk), .rst(rst), .stall(stall), .flush(flush),
        .in_valid(in_valid), .in_data(in_data), .cnt_clr(cnt_clr),
        .out_valid(out_valid2), .out_data(out_data2), .hold_cnt(hold_cnt2),
        .bubble_cnt(bubble_cnt2), .squash_cnt(squash_cnt2)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [5:0] s, input logic f, input logic v,
                         input logic [31:0] d, input logic c);
        stall = s; flush = f; in_valid = v; in_data = d; cnt_clr = c;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        drive(6'b000000, 1'b0, 1'b0, 32'h0, 1'b0);
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        drive(6'b110000, 1'b1, 1'b1, 32'hFFFF_FFFF, 1'b1);
        tick();
        rst = 1'b0;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %0b want 0", out_valid); end
        checks++; if (out_data !== 32'h0) begin errors++; $display("FAIL reset_data got %h want 00000000", out_data); end
        checks++; if (out_data2 !== 32'h0) begin errors++; $display("FAIL reset_data_nc got %h want 00000000", out_data2); end
        checks++; if (hold_cnt !== 4'h0 || bubble_cnt !== 4'h0 || squash_cnt !== 4'h0) begin
            errors++; $display("FAIL reset_cnts got %h %h %h want 0 0 0", hold_cnt, bubble_cnt, squash_cnt); end
    endtask

    task automatic test_load();
        drive(6'b000000, 1'b0, 1'b1, 32'hDEADBEEF, 1'b0);
        tick();
        checks++; if (out_valid !== 1'b1 || out_data !== 32'hDEADBEEF) begin
            errors++; $display("FAIL load got %0b/%h want 1/deadbeef", out_valid, out_data); end
        // unrelated stall bits set, up=0 -> still a load; invalid payload is not gated
        drive(6'b101111, 1'b0, 1'b0, 32'h0000_1234, 1'b0);
        tick();
        checks++; if (out_valid !== 1'b0 || out_data !== 32'h0000_1234) begin
            errors++; $display("FAIL load_invalid got %0b/%h want 0/00001234", out_valid, out_data); end
        checks++; if (hold_cnt !== 4'h0 || bubble_cnt !== 4'h0) begin
            errors++; $display("FAIL load_no_count got %h %h want 0 0", hold_cnt, bubble_cnt); end
    endtask

    task automatic test_hold_bubble();
        do_reset();
        drive(6'b000000, 1'b0, 1'b1, 32'h11, 1'b0);
        tick();
        drive(6'b110000, 1'b0, 1'b0, 32'h99, 1'b0);
        for (int i = 0; i < 3; i++) tick();
        checks++; if (out_valid !== 1'b1 || out_data !== 32'h11) begin
            errors++; $display("FAIL hold_data got %0b/%h want 1/00000011", out_valid, out_data); end
        checks++; if (hold_cnt !== 4'd3) begin errors++; $display("FAIL hold_cnt got %0d want 3", hold_cnt); end
        drive(6'b010000, 1'b0, 1'b1, 32'h99, 1'b0);
        tick();
        checks++; if (out_valid !== 1'b0 || out_data !== 32'h0) begin
            errors++; $display("FAIL bubble got %0b/%h want 0/00000000", out_valid, out_data); end
        checks++; if (bubble_cnt !== 4'd1 || hold_cnt !== 4'd3) begin
            errors++; $display("FAIL bubble_cnt got %0d hold %0d want 1 hold 3", bubble_cnt, hold_cnt); end
    endtask

    task automatic test_flush();
        do_reset();
        drive(6'b000000, 1'b0, 1'b1, 32'h77, 1'b0);
        tick();
        drive(6'b000000, 1'b1, 1'b1, 32'h88, 1'b0);
        tick();
        checks++; if (out_valid !== 1'b0 || out_data !== 32'h0) begin
            errors++; $display("FAIL flush got %0b/%h want 0/00000000", out_valid, out_data); end
        checks++; if (squash_cnt !== 4'd1) begin errors++; $display("FAIL squash_cnt got %0d want 1", squash_cnt); end
        drive(6'b110000, 1'b1, 1'b1, 32'h88, 1'b0);
        tick();
        checks++; if (squash_cnt !== 4'd1 || hold_cnt !== 4'd0) begin
            errors++; $display("FAIL squash_empty got %0d hold %0d want 1 hold 0", squash_cnt, hold_cnt); end
        checks++; if (out_data2 !== 32'h77 || out_valid2 !== 1'b0) begin
            errors++; $display("FAIL flush_keep got %0b/%h want 0/00000077", out_valid2, out_data2); end
    endtask

    task automatic test_no_clear();
        do_reset();
        drive(6'b000000, 1'b0, 1'b1, 32'hA5A5A5A5, 1'b0);
        tick();
        drive(6'b010000, 1'b0, 1'b1, 32'h0, 1'b0);
        tick();
        checks++; if (out_valid2 !== 1'b0 || out_data2 !== 32'hA5A5A5A5) begin
            errors++; $display("FAIL bubble_keep got %0b/%h want 0/a5a5a5a5", out_valid2, out_data2); end
        checks++; if (out_data !== 32'h0) begin
            errors++; $display("FAIL bubble_clear got %h want 00000000", out_data); end
    endtask

    task automatic test_saturation();
        do_reset();
        drive(6'b000000, 1'b0, 1'b1, 32'h42, 1'b0);
        tick();
        drive(6'b110000, 1'b0, 1'b0, 32'h0, 1'b0);
        for (int i = 0; i < 14; i++) tick();
        checks++; if (hold_cnt !== 4'd14) begin errors++; $display("FAIL hold_cnt14 got %0d want 14", hold_cnt); end
        for (int i = 0; i < 6; i++) tick();
        checks++; if (hold_cnt !== 4'hF) begin errors++; $display("FAIL hold_sat got %h want f", hold_cnt); end
        drive(6'b110000, 1'b0, 1'b0, 32'h0, 1'b1);
        tick();
        checks++; if (hold_cnt !== 4'h0) begin errors++; $display("FAIL cnt_clr got %h want 0", hold_cnt); end
        checks++; if (out_valid !== 1'b1 || out_data !== 32'h42) begin
            errors++; $display("FAIL clr_no_data got %0b/%h want 1/00000042", out_valid, out_data); end
        cnt_clr = 1'b0;
    endtask

    task automatic test_reset_mid_hold();
        do_reset();
        drive(6'b000000, 1'b0, 1'b1, 32'h55, 1'b0);
        tick();
        drive(6'b110000, 1'b0, 1'b0, 32'h0, 1'b0);
        tick();
        checks++; if (hold_cnt !== 4'd1 || out_data !== 32'h55) begin
            errors++; $display("FAIL pre_rst_hold got %0d/%h want 1/00000055", hold_cnt, out_data); end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checks++; if (out_valid !== 1'b0 || out_data !== 32'h0 || hold_cnt !== 4'h0) begin
            errors++; $display("FAIL rst_hold got %0b/%h cnt %0d want 0/00000000 cnt 0", out_valid, out_data, hold_cnt); end
        checks++; if (out_data2 !== 32'h0) begin
            errors++; $display("FAIL rst_hold_nc got %h want 00000000", out_data2); end
        drive(6'b000000, 1'b0, 1'b1, 32'h66, 1'b0);
        tick();
        checks++; if (out_valid !== 1'b1 || out_data !== 32'h66) begin
            errors++; $display("FAIL post_rst_load got %0b/%h want 1/00000066", out_valid, out_data); end
    endtask

    initial begin
        rst = 1'b1;
        drive(6'b000000, 1'b0, 1'b0, 32'h0, 1'b0);
        test_reset();
        test_load();
        test_hold_bubble();
        test_flush();
        test_no_clear();
        test_saturation();
        test_reset_mid_hold();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
